l1dcache_responder: RTL

Server end of the l1dcache_core_if protocol: the L1 data cache that answers load/store requests from the store queue and core.
- Direct-mapped, write-through, no-write-allocate.
- Single-cycle response on hit; nack (resp_ack=0) on miss or busy, requester retries.
- Refills whole lines from a backing-memory port; stores drain through a one-entry write buffer.

---
 rtl/l1dcache_responder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/l1dcache_responder.sv
// l1dcache_responder: direct-mapped, write-through, no-write-allocate L1 data cache.
// Whole-line refill from backing memory; stores are posted through a one-entry write buffer.
module l1dcache_responder #(
  parameter int ADDR_W         = 30,
  parameter int LINE_WORDS_EXP = 2,
  parameter int SETS_EXP       = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [3:0]        req_mask,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  output logic              resp_ack,
  output logic [31:0]       resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [3:0]        mem_req_mask,
  output logic [31:0]       mem_req_data,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data
);
  localparam int OW = LINE_WORDS_EXP;
  localparam int IW = SETS_EXP;
  localparam int TW = ADDR_W - OW - IW;
  localparam int LW = ADDR_W - OW;
  typedef enum logic [1:0] {IDLE, REFILL_REQ, REFILL_DATA} state_t;
  state_t             state_q, state_d;
  logic [OW-1:0]      cnt_q, cnt_d;
  logic [(1<<IW)-1:0] valid_q, valid_d;
  logic [LW-1:0]      line_q, line_d;
  logic               r_valid_q, r_valid_d, r_we_q, r_we_d;
  logic [3:0]         r_mask_q, r_mask_d;
  logic [ADDR_W-1:0]  r_addr_q, r_addr_d;
  logic [31:0]        r_data_q, r_data_d;
  logic               wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0]  wb_addr_q, wb_addr_d;
  logic [3:0]         wb_mask_q, wb_mask_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic               byp_valid_q, byp_valid_d;
  logic [ADDR_W-1:0]  byp_addr_q, byp_addr_d;
  logic [31:0]        byp_data_q, byp_data_d;
  logic [TW-1:0]      tag_mem [1<<IW];
  logic [31:0]        data_mem [1<<(OW+IW)];
  logic [IW-1:0]      r_idx, l_idx;
  logic [OW+IW-1:0]   r_word;
  logic [31:0]        cur_word, merged;
  logic               idle, hit, wb_free, drain, ld_hit, ld_miss, st_ok, st_hit, beat, last, rd_req;
  always_comb begin
    r_idx    = r_addr_q[OW +: IW];
    r_word   = r_addr_q[OW+IW-1:0];
    l_idx    = line_q[IW-1:0];
    idle     = state_q == IDLE;
    hit      = valid_q[r_idx] && tag_mem[r_idx] == r_addr_q[ADDR_W-1 -: TW];
    // A store hit last cycle is read back from here so a follow-up load never sees the old word
    cur_word = (byp_valid_q && byp_addr_q == r_addr_q) ? byp_data_q : data_mem[r_word];
    merged   = cur_word;
    for (int b = 0; b < 4; b++) merged[8*b +: 8] = r_mask_q[b] ? r_data_q[8*b +: 8] : cur_word[8*b +: 8];
    drain    = wb_valid_q && mem_req_ready;
    wb_free  = !wb_valid_q || mem_req_ready;
    ld_hit   = r_valid_q && !r_we_q && idle && hit;
    ld_miss  = r_valid_q && !r_we_q && idle && !hit;
    st_ok    = r_valid_q && r_we_q && idle && wb_free;
    st_hit   = st_ok && hit;
    beat     = state_q == REFILL_DATA && mem_resp_valid;
    last     = beat && cnt_q == '1;
    rd_req   = state_q == REFILL_REQ && !wb_valid_q;
    resp_ack      = ld_hit || st_ok;
    resp_data     = ld_hit ? cur_word : 32'h0;
    mem_req_valid = wb_valid_q || rd_req;
    mem_req_we    = wb_valid_q;
    mem_req_addr  = wb_valid_q ? wb_addr_q : rd_req ? {line_q, {OW{1'b0}}} : '0;
    mem_req_mask  = wb_valid_q ? wb_mask_q : 4'h0;
    mem_req_data  = wb_valid_q ? wb_data_q : 32'h0;
    state_d = ld_miss ? REFILL_REQ : (rd_req && mem_req_ready) ? REFILL_DATA : last ? IDLE : state_q;
    line_d  = ld_miss ? r_addr_q[ADDR_W-1:OW] : line_q;
    cnt_d   = beat ? cnt_q + 1'b1 : cnt_q;
    valid_d = valid_q;
    if (rd_req && mem_req_ready) valid_d[l_idx] = 1'b0;
    if (last) valid_d[l_idx] = 1'b1;
    r_valid_d   = req_valid;
    r_we_d      = req_we;
    r_mask_d    = req_mask;
    r_addr_d    = req_addr;
    r_data_d    = req_data;
    wb_valid_d  = st_ok || (wb_valid_q && !drain);
    wb_addr_d   = st_ok ? r_addr_q : wb_addr_q;
    wb_mask_d   = st_ok ? r_mask_q : wb_mask_q;
    wb_data_d   = st_ok ? r_data_q : wb_data_q;
    byp_valid_d = st_hit;
    byp_addr_d  = r_addr_q;
    byp_data_d  = merged;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      valid_q     <= '0;
      line_q      <= '0;
      r_valid_q   <= 1'b0;
      r_we_q      <= 1'b0;
      r_mask_q    <= 4'h0;
      r_addr_q    <= '0;
      r_data_q    <= 32'h0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_mask_q   <= 4'h0;
      wb_data_q   <= 32'h0;
      byp_valid_q <= 1'b0;
      byp_addr_q  <= '0;
      byp_data_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      line_q      <= line_d;
      r_valid_q   <= r_valid_d;
      r_we_q      <= r_we_d;
      r_mask_q    <= r_mask_d;
      r_addr_q    <= r_addr_d;
      r_data_q    <= r_data_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_mask_q   <= wb_mask_d;
      wb_data_q   <= wb_data_d;
      byp_valid_q <= byp_valid_d;
      byp_addr_q  <= byp_addr_d;
      byp_data_q  <= byp_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (last) tag_mem[l_idx] <= line_q[LW-1 -: TW];
    if (beat) data_mem[{l_idx, cnt_q}] <= mem_resp_data;
    if (st_hit) data_mem[r_word] <= merged;
  end
endmodule
